// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared FSM encoding and cache-line/word geometry for the CPU memory path
package mem_access_unit_pkg;
  localparam int LINE_BITS     = 256;
  localparam int WORD_BITS     = 32;
  localparam int LINE_OFF_BITS = 5;
  localparam int WORD_IDX_LSB  = 2;
  localparam int WORD_IDX_BITS = 3;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_e;
endpackage

// File: rtl/mem_access_unit_line_word_mux.sv
// line_word_mux: selects one word of a line and splices a replacement word into the same slot
module line_word_mux #(
  parameter int LINE_BITS = 256,
  parameter int WORD_BITS = 32,
  parameter int IDX_BITS  = 3
) (
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [IDX_BITS-1:0]  idx_i,
  input  logic [WORD_BITS-1:0] word_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic [LINE_BITS-1:0] line_o
);
  // word 0 sits in the least-significant bits of the line
  always_comb begin
    word_o = '0;
    line_o = line_i;
    for (int k = 0; k < LINE_BITS / WORD_BITS; k++)
      if (idx_i == k[IDX_BITS-1:0]) begin
        word_o = line_i[k*WORD_BITS +: WORD_BITS];
        line_o[k*WORD_BITS +: WORD_BITS] = word_i;
      end
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bridge that turns word loads/stores into off-chip line read / read-modify-write transactions
module mem_access_unit #(
  parameter int LINE_BITS = mem_access_unit_pkg::LINE_BITS,
  parameter int WORD_BITS = mem_access_unit_pkg::WORD_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          addr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] rdata_o,
  output logic                 mem_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  import mem_access_unit_pkg::*;

  state_e               state_q, state_d;
  logic [31:2]          addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d, sel_word;
  logic                 wr_q, wr_d;
  logic [LINE_BITS-1:0] line_q, line_d, merged_line;
  logic                 req;
  logic                 unused_addr_lo;

  assign req            = start_i && (MemRead_i || MemWrite_i);
  assign unused_addr_lo = ^addr_i[1:0];

  line_word_mux #(
    .LINE_BITS(LINE_BITS),
    .WORD_BITS(WORD_BITS),
    .IDX_BITS (WORD_IDX_BITS)
  ) u_mux (
    .line_i(mem_data_i),
    .idx_i (addr_q[WORD_IDX_LSB +: WORD_IDX_BITS]),
    .word_i(wdata_q),
    .word_o(sel_word),
    .line_o(merged_line)
  );

  // every transaction reads the line first; a pending store merges into it and writes it back
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = RD_REQ;
        addr_d  = addr_i[31:2];
        wdata_d = wdata_i;
        wr_d    = MemWrite_i;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (mem_ack_i) begin
        rdata_d = sel_word;
        line_d  = wr_q ? merged_line : mem_data_i;
        state_d = wr_q ? WR_REQ : DONE;
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: if (mem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // reset abandons any in-flight transaction and clears all captured state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_stall_o  = rst_i && ((state_q == IDLE) ? req : (state_q != DONE));
  assign mem_enable_o = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_write_o  = state_q == WR_REQ;
  assign mem_addr_o   = {addr_q[31:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
  assign mem_data_o   = ((state_q == WR_REQ) || (state_q == WR_WAIT)) ? line_q : '0;
  assign rdata_o      = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic         clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0]  addr_i = '0, wdata_i = '0, rdata_o, mem_addr_o;
  logic         mem_stall_o, mem_enable_o, mem_write_o;
  logic [255:0] mem_data_o, mem_data_i = '0, pat, exp_line, wl;
  logic [31:0]  ra;
  logic         to;
  int           tests = 0, fails = 0;
  int           stall_n, rd_n, wr_n, rs;

  always #5 clk_i = ~clk_i;

  mem_access_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .mem_stall_o(mem_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  // drives one request from IDLE to DONE, acking each strobe d cycles later; returns in the DONE cycle
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic stray, input logic drop_start,
                        output int o_stall, output int o_rd, output int o_wr, output int o_rs,
                        output logic [31:0] o_ra, output logic [255:0] o_wl, output logic o_to);
    int last_rs, last_ws;
    last_rs = -100; last_ws = -100; o_rs = -1;
    o_stall = 0; o_rd = 0; o_wr = 0; o_ra = '0; o_wl = '0; o_to = 1'b1;
    start_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd;
    for (int c = 0; c < 40; c++) begin
      mem_ack_i = (c == last_rs + d) || (c == last_ws + d) || (stray && c < 2);
      if (drop_start && c > 0) start_i = 1'b0;
      #1;
      if (mem_enable_o && !mem_write_o) begin o_rd++; last_rs = c; o_ra = mem_addr_o; if (o_rd == 1) o_rs = c; end
      if (mem_enable_o && mem_write_o) begin o_wr++; last_ws = c; o_wl = mem_data_o; end
      if (!mem_stall_o) begin o_to = 1'b0; break; end
      o_stall++;
      step();
    end
    mem_ack_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic test_reset;
    start_i = 1'b1; MemRead_i = 1'b1; addr_i = 32'h24;
    step(); step();
    tests++; if (mem_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b required 0", mem_stall_o); end
    tests++; if (mem_enable_o !== 1'b0) begin fails++; $display("FAIL reset_enable: got %b required 0", mem_enable_o); end
    tests++; if (mem_write_o !== 1'b0) begin fails++; $display("FAIL reset_write: got %b required 0", mem_write_o); end
    tests++; if (mem_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h required 0", mem_addr_o); end
    tests++; if (mem_data_o !== 256'h0) begin fails++; $display("FAIL reset_data: got %h required 0", mem_data_o); end
    tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h required 0", rdata_o); end
    start_i = 1'b0; MemRead_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_load;
    mem_data_i = pat;
    run_op(1'b1, 1'b0, 32'h24, 32'h0, 3, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL load_timeout: got %b required 0", to); end
    tests++; if (ra !== 32'h20) begin fails++; $display("FAIL load_addr: got %h required 00000020", ra); end
    tests++; if (rd_n !== 1 || wr_n !== 0) begin fails++; $display("FAIL load_strobes: got rd %0d wr %0d required rd 1 wr 0", rd_n, wr_n); end
    tests++; if (stall_n !== 5) begin fails++; $display("FAIL load_stall_cycles: got %0d required 5", stall_n); end
    tests++; if (rdata_o !== 32'hC0DE0001) begin fails++; $display("FAIL load_rdata: got %h required c0de0001", rdata_o); end
    tests++; if (mem_data_o !== 256'h0) begin fails++; $display("FAIL load_data_out: got %h required 0", mem_data_o); end
    step();
    run_op(1'b1, 1'b0, 32'h2C, 32'h0, 1, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (stall_n !== 3) begin fails++; $display("FAIL load_min_stall: got %0d required 3", stall_n); end
    tests++; if (rdata_o !== 32'hC0DE0003) begin fails++; $display("FAIL load_min_rdata: got %h required c0de0003", rdata_o); end
    step();
  endtask

  task automatic test_store;
    mem_data_i = '0;
    run_op(1'b0, 1'b1, 32'h1C, 32'hDEADBEEF, 1, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL store_timeout: got %b required 0", to); end
    tests++; if (wl !== {32'hDEADBEEF, 224'h0}) begin fails++; $display("FAIL store_line: got %h required deadbeef followed by zeros", wl); end
    tests++; if (rd_n !== 1 || wr_n !== 1) begin fails++; $display("FAIL store_strobes: got rd %0d wr %0d required rd 1 wr 1", rd_n, wr_n); end
    tests++; if (stall_n !== 5) begin fails++; $display("FAIL store_stall_cycles: got %0d required 5", stall_n); end
    tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL store_rdata: got %h required 0", rdata_o); end
    tests++; if (mem_data_o !== 256'h0) begin fails++; $display("FAIL store_data_done: got %h required 0", mem_data_o); end
    step();
  endtask

  task automatic test_rmw;
    mem_data_i = pat;
    exp_line = pat;
    exp_line[95:64] = 32'h12345678;
    run_op(1'b1, 1'b1, 32'h4B, 32'h12345678, 2, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (wl !== exp_line) begin fails++; $display("FAIL rmw_line: got %h required %h", wl, exp_line); end
    tests++; if (rdata_o !== 32'hC0DE0002) begin fails++; $display("FAIL rmw_rdata: got %h required c0de0002", rdata_o); end
    tests++; if (ra !== 32'h40) begin fails++; $display("FAIL rmw_addr: got %h required 00000040", ra); end
    tests++; if (stall_n !== 7) begin fails++; $display("FAIL rmw_stall_cycles: got %0d required 7", stall_n); end
    step();
  endtask

  task automatic test_back_to_back;
    mem_data_i = pat;
    run_op(1'b1, 1'b0, 32'h04, 32'h0, 1, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (rdata_o !== 32'hC0DE0001) begin fails++; $display("FAIL b2b_load_rdata: got %h required c0de0001", rdata_o); end
    step();
    exp_line = pat;
    exp_line[95:64] = 32'hAAAA5555;
    run_op(1'b0, 1'b1, 32'h08, 32'hAAAA5555, 1, 1'b0, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (rs !== 1) begin fails++; $display("FAIL b2b_accept_cycle: got %0d required 1", rs); end
    tests++; if (rd_n !== 1 || wr_n !== 1) begin fails++; $display("FAIL b2b_strobes: got rd %0d wr %0d required rd 1 wr 1", rd_n, wr_n); end
    tests++; if (wl !== exp_line) begin fails++; $display("FAIL b2b_store_line: got %h required %h", wl, exp_line); end
    tests++; if (rdata_o !== 32'hC0DE0002) begin fails++; $display("FAIL b2b_store_rdata: got %h required c0de0002", rdata_o); end
    step();
  endtask

  task automatic test_reset_mid;
    mem_data_i = pat;
    start_i = 1'b1; MemRead_i = 1'b1; addr_i = 32'h24;
    step(); step();
    start_i = 1'b0; MemRead_i = 1'b0;
    #1; rst_i = 1'b0; #1;
    tests++; if (mem_stall_o !== 1'b0) begin fails++; $display("FAIL rstmid_stall: got %b required 0", mem_stall_o); end
    tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL rstmid_rdata: got %h required 0", rdata_o); end
    #2; rst_i = 1'b1;
    step();
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    tests++; if (mem_stall_o !== 1'b0) begin fails++; $display("FAIL rstmid_late_ack_stall: got %b required 0", mem_stall_o); end
    tests++; if (mem_enable_o !== 1'b0) begin fails++; $display("FAIL rstmid_late_ack_enable: got %b required 0", mem_enable_o); end
    tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL rstmid_late_ack_rdata: got %h required 0", rdata_o); end
    step();
  endtask

  task automatic test_start_gate;
    mem_data_i = pat;
    start_i = 1'b0; MemRead_i = 1'b1; addr_i = 32'h38;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (mem_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin fails++; $display("FAIL gate_idle: got stall %b enable %b required 0 0", mem_stall_o, mem_enable_o); end
      step();
    end
    run_op(1'b1, 1'b0, 32'h38, 32'h0, 1, 1'b0, 1'b1, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (rs !== 1) begin fails++; $display("FAIL gate_start_cycle: got %0d required 1", rs); end
    tests++; if (to !== 1'b0 || stall_n !== 3) begin fails++; $display("FAIL gate_no_abort: got timeout %b stall %0d required 0 3", to, stall_n); end
    tests++; if (rdata_o !== 32'hC0DE0006) begin fails++; $display("FAIL gate_rdata: got %h required c0de0006", rdata_o); end
    step();
  endtask

  task automatic test_stray_ack;
    mem_data_i = pat;
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    tests++; if (mem_stall_o !== 1'b0 || mem_enable_o !== 1'b0) begin fails++; $display("FAIL stray_idle: got stall %b enable %b required 0 0", mem_stall_o, mem_enable_o); end
    step();
    run_op(1'b1, 1'b0, 32'h30, 32'h0, 3, 1'b1, 1'b0, stall_n, rd_n, wr_n, rs, ra, wl, to);
    tests++; if (stall_n !== 5) begin fails++; $display("FAIL stray_stall_cycles: got %0d required 5", stall_n); end
    tests++; if (rdata_o !== 32'hC0DE0004) begin fails++; $display("FAIL stray_rdata: got %h required c0de0004", rdata_o); end
    tests++; if (rd_n !== 1) begin fails++; $display("FAIL stray_strobes: got %0d required 1", rd_n); end
    step();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) pat[k*32 +: 32] = 32'hC0DE0000 + k;
    test_reset();
    test_load();
    test_store();
    test_rmw();
    test_back_to_back();
    test_reset_mid();
    test_start_gate();
    test_stray_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter LINE_BITS, default 256: off-chip line width in bits.
REQ-002 SHALL have parameter WORD_BITS, default 32: pipeline data word width in bits.
REQ-003 SHALL have port clk_i  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start_i  input  1  CPU run enable; while low, no new request is accepted.
REQ-006 SHALL have port MemRead_i  input  1  MEM-stage load request, from the EX/MEM register.
REQ-007 SHALL have port MemWrite_i  input  1  MEM-stage store request, from the EX/MEM register.
REQ-008 SHALL have port addr_i  input  32  byte address (ALU result).
REQ-009 SHALL have port wdata_i  input  32  store data.
REQ-010 SHALL have port rdata_o  output  32  load data.
REQ-011 SHALL have port mem_stall_o  output  1  stall to every pipeline register; it drives their mem_stall_i inputs.
REQ-012 SHALL have port mem_enable_o  output  1  off-chip request strobe.
REQ-013 SHALL have port mem_write_o  output  1  off-chip write qualifier.
REQ-014 SHALL have port mem_addr_o  output  32  off-chip line address.
REQ-015 SHALL have port mem_data_o  output  256  off-chip write line.
REQ-016 SHALL have port mem_data_i  input  256  off-chip read line.
REQ-017 SHALL have port mem_ack_i  input  1  off-chip completion, one cycle, arriving at any latency of 1 or more cycles.

Function
REQ-018 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-019 IDLE: if start_i and (MemRead_i or MemWrite_i), SHALL capture addr_i, wdata_i and the op, then go to RD_REQ; otherwise stay in IDLE.
REQ-020 mem_stall_o SHALL be combinationally high in IDLE while a qualifying request is present, SHALL be high in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT, and SHALL be low in DONE.
REQ-021 RD_REQ: mem_enable_o=1, mem_write_o=0 and mem_addr_o={addr[31:5],5'b0} for exactly one cycle, then go to RD_WAIT.
REQ-022 RD_WAIT: mem_enable_o=0; on mem_ack_i, SHALL latch mem_data_i and load rdata_o with word addr[4:2] (word 0 = bits 31:0).
REQ-023 On RD_WAIT ack: a read-only op SHALL go to DONE; any op with MemWrite SHALL replace word addr[4:2] of the latched line with wdata, then go to WR_REQ.
REQ-024 WR_REQ: mem_enable_o=1, mem_write_o=1, same line address and mem_data_o = merged line for one cycle, then go to WR_WAIT.
REQ-025 WR_WAIT: on mem_ack_i, SHALL go to DONE.
REQ-026 DONE: one cycle, stall low so the EX/MEM register advances, then go to IDLE.
REQ-027 When MemRead_i and MemWrite_i are both high, the op SHALL be a read-modify-write, and rdata_o SHALL return the pre-write word.
REQ-028 addr[1:0] SHALL be ignored; there SHALL be no alignment fault.
REQ-029 mem_ack_i outside RD_WAIT and WR_WAIT (including the REQ states and IDLE) SHALL be ignored.
REQ-030 rdata_o SHALL hold its value until the next RD_WAIT ack.
REQ-031 mem_data_o SHALL be zero except in WR_REQ and WR_WAIT.
REQ-032 start_i falling mid-operation SHALL NOT abort the operation; it only blocks acceptance in IDLE.
REQ-033 Minimum occupancy SHALL be read 4 cycles (IDLE→RD_REQ→RD_WAIT→DONE with ack one cycle after the strobe) and write 6 cycles.

Reset
REQ-034 rst_i low SHALL, asynchronously and in any state: set the state to IDLE; set rdata_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o and the captured registers to 0; and drop mem_stall_o (no request is pending in IDLE).
REQ-035 A reset during RD_WAIT or WR_WAIT SHALL abandon the transaction; a late mem_ack_i after reset SHALL be ignored.

Structure
REQ-036 FSM state encoding, LINE_BITS, WORD_BITS and the offset constants (word index bits 4:2, line offset 5 bits) SHALL live in the shared cpu package.
REQ-037 Word select/merge SHALL be a sub-module line_word_mux: combinational, taking the line, index and new word, and producing the selected word and the merged line.

Verification
REQ-038 Load at 0x0000_0024 with ack 3 cycles after strobe: mem_addr_o=0x20, rdata_o=word1 of the line, and stall high for exactly 5 cycles.
REQ-039 Store 0xDEADBEEF to 0x1C, line preloaded with 0: write strobe with mem_data_o[255:224]=0xDEADBEEF and the rest 0; stall low only in DONE.
REQ-040 Back-to-back load then store: the second request is accepted in the IDLE cycle after DONE, and there is no duplicate strobe for the first.
REQ-041 Reset pulse during RD_WAIT, then ack: no state change, stall 0, mem_enable_o 0, rdata_o 0.
REQ-042 start_i=0 with MemRead_i=1: no strobe and stall 0; raising start_i begins the read the same cycle.
REQ-043 Stray ack in IDLE or RD_REQ: ignored, so the FSM still waits for the real ack.
